// File: rtl/jk_pkg.sv
// jk_pkg: shared JK flip-flop definitions.
// Holds the monitor state encoding and the JK next-state function.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TOG  = 2'b11;

  function automatic logic jk_next(
    input logic q,
    input logic j,
    input logic k
  );
    logic r;
    case ({j, k})
      HOLD:    r = q;
      RST:     r = 1'b0;
      SET:     r = 1'b1;
      TOG:     r = ~q;
      default: r = 1'bx;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Synchronous active-high clear; at most one step per edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // clear on reset, otherwise step until saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/jk_monitor.sv
// jk_monitor: observes J/K/Q of a JK flip-flop and checks Q
// against an internal reference model one cycle later.
module jk_monitor
  import jk_pkg::*;
#(
  parameter int ERR_CNT_W     = 8,
  parameter bit RESYNC_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 check_en,
  input  logic                 J,
  input  logic                 K,
  input  logic                 Q,
  output logic                 exp_q,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] chk_count,
  output logic                 busy
);

  state_t state;
  state_t state_n;
  logic   exp_n;
  logic   do_cmp;
  logic   mis;

  // next state, model update and compare decision
  always_comb begin
    state_n = state;
    exp_n   = exp_q;
    do_cmp  = 1'b0;
    mis     = 1'b0;
    case (state)
      IDLE: begin
        if (check_en) state_n = SYNC;
      end
      SYNC: begin
        if (!check_en) begin
          state_n = IDLE;
        end else begin
          exp_n   = jk_next(Q, J, K);
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (!check_en) begin
          state_n = IDLE;
        end else begin
          do_cmp = 1'b1;
          mis    = (Q != exp_q);
          if (mis && RESYNC_ON_ERR) begin
            exp_n = jk_next(Q, J, K);
          end else begin
            exp_n = jk_next(exp_q, J, K);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, model and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      exp_q      <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      exp_q      <= exp_n;
      err        <= mis;
      err_sticky <= err_sticky | mis;
      busy       <= (state_n == CHECK);
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(mis),
    .cnt(err_count)
  );

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_chk_cnt (
    .clk(clk),
    .rst(rst),
    .inc(do_cmp),
    .cnt(chk_count)
  );

endmodule

// File: tb/tb_jk_monitor.sv
// tb_jk_monitor: scoreboard bench for three monitor variants
// (resync, free-running, 2-bit counters) sharing one stimulus.
module tb_jk_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_en = 1'b0;
  logic J = 1'b0;
  logic K = 1'b0;
  logic Q = 1'b0;

  logic       x0, r0, s0, b0;
  logic [7:0] ec0, cc0;
  logic       x1, r1, s1, b1;
  logic [7:0] ec1, cc1;
  logic       x2, r2, s2, b2;
  logic [1:0] ec2, cc2;

  always #5 clk = ~clk;

  jk_monitor #(.ERR_CNT_W(8), .RESYNC_ON_ERR(1'b1)) u0 (
    .clk(clk), .rst(rst), .check_en(check_en),
    .J(J), .K(K), .Q(Q),
    .exp_q(x0), .err(r0), .err_sticky(s0),
    .err_count(ec0), .chk_count(cc0), .busy(b0)
  );

  jk_monitor #(.ERR_CNT_W(8), .RESYNC_ON_ERR(1'b0)) u1 (
    .clk(clk), .rst(rst), .check_en(check_en),
    .J(J), .K(K), .Q(Q),
    .exp_q(x1), .err(r1), .err_sticky(s1),
    .err_count(ec1), .chk_count(cc1), .busy(b1)
  );

  jk_monitor #(.ERR_CNT_W(2), .RESYNC_ON_ERR(1'b1)) u2 (
    .clk(clk), .rst(rst), .check_en(check_en),
    .J(J), .K(K), .Q(Q),
    .exp_q(x2), .err(r2), .err_sticky(s2),
    .err_count(ec2), .chk_count(cc2), .busy(b2)
  );

  typedef struct {
    int   st;
    logic eq;
    logic er;
    logic sk;
    int   ec;
    int   cc;
  } mst_t;

  typedef logic [2:0][19:0] exp_t;

  localparam int WS[3] = '{8, 8, 2};
  localparam bit RS[3] = '{1'b1, 1'b0, 1'b1};

  mst_t m[3];
  exp_t sb[$];
  exp_t e;
  logic ff_q = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic f(input logic q, j, k);
    if (j && k) return ~q;
    if (j) return 1'b1;
    if (k) return 1'b0;
    return q;
  endfunction

  function automatic mst_t mstep(
    input mst_t s, input int w, input bit rs,
    input logic r, en, j, k, q
  );
    mst_t n;
    int   mx;
    logic bad;
    n = s;
    n.er = 1'b0;
    mx = (1 << w) - 1;
    if (r) begin
      n = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
    end else if (s.st == 0) begin
      if (en) n.st = 1;
    end else if (!en) begin
      n.st = 0;
    end else if (s.st == 1) begin
      n.eq = f(q, j, k);
      n.st = 2;
    end else begin
      bad = (q !== s.eq);
      if (s.cc < mx) n.cc = s.cc + 1;
      if (bad) begin
        n.er = 1'b1;
        n.sk = 1'b1;
        if (s.ec < mx) n.ec = s.ec + 1;
      end
      n.eq = (bad && rs) ? f(q, j, k) : f(s.eq, j, k);
    end
    return n;
  endfunction

  function automatic logic [19:0] pack(input mst_t s);
    return {s.eq, s.er, s.sk, 8'(s.ec), 8'(s.cc), s.st == 2};
  endfunction

  function automatic logic [19:0] obs(input int i);
    case (i)
      0: return {x0, r0, s0, ec0, cc0, b0};
      1: return {x1, r1, s1, ec1, cc1, b1};
      default: return {x2, r2, s2, 6'd0, ec2, 6'd0, cc2, b2};
    endcase
  endfunction

  // drive one cycle, push expectations, wait past the edge
  task automatic step(
    input logic r, en, j, k,
    input bit frc = 1'b0, input logic fq = 1'b0
  );
    exp_t x;
    rst = r;
    check_en = en;
    J = j;
    K = k;
    Q = frc ? fq : ff_q;
    for (int i = 0; i < 3; i++) begin
      m[i] = mstep(m[i], WS[i], RS[i], r, en, j, k, Q);
      x[i] = pack(m[i]);
    end
    sb.push_back(x);
    ff_q = r ? 1'b0 : f(ff_q, j, k);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== e[i]) begin
          n_bad++;
          $display("FAIL reset dut%0d got %h want %h", i, obs(i), e[i]);
        end
      end
    end
    n_cmp++;
    if ({x0, r0, s0, ec0, cc0, b0} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_vals got %h want 0",
               {x0, r0, s0, ec0, cc0, b0});
    end
  endtask

  task automatic test_basic();
    logic [1:0] jk[6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, jk[c][1], jk[c][0]);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== e[i]) begin
          n_bad++;
          $display("FAIL basic%0d dut%0d got %h want %h", c, i, obs(i), e[i]);
        end
      end
    end
    n_cmp++;
    if ({cc0, ec0, s0} !== {8'd4, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_cnt got cc=%0d ec=%0d sk=%b want 4 0 0",
               cc0, ec0, s0);
    end
  endtask

  task automatic test_force_err();
    logic [3:0] tab[9] = '{4'b0100, 4'b0111, 4'b0100, 4'b0000,
                           4'b0000, 4'b0000, 4'b0000, 4'b0100,
                           4'b0000};
    for (int c = 0; c < 9; c++) begin
      if (c == 4) ff_q = ~ff_q;
      step(1'b0, 1'b1, tab[c][3], tab[c][2], tab[c][1], tab[c][0]);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== e[i]) begin
          n_bad++;
          $display("FAIL force%0d dut%0d got %h want %h", c, i, obs(i), e[i]);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if ({r0, s0, ec0} !== {1'b1, 1'b1, 8'd1}) begin
          n_bad++;
          $display("FAIL err_pulse got err=%b sk=%b ec=%0d want 1 1 1",
                   r0, s0, ec0);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if ({r0, s0} !== 2'b01) begin
          n_bad++;
          $display("FAIL resync got err=%b sk=%b want 0 1", r0, s0);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if ({r1, r0} !== 2'b10) begin
          n_bad++;
          $display("FAIL freerun got nr=%b rs=%b want 1 0", r1, r0);
        end
      end
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== e[i]) begin
          n_bad++;
          $display("FAIL sat%0d dut%0d got %h want %h", c, i, obs(i), e[i]);
        end
      end
    end
    n_cmp++;
    if ({ec2, cc2} !== 4'b1111) begin
      n_bad++;
      $display("FAIL sat_cnt got ec=%0d cc=%0d want 3 3", ec2, cc2);
    end
  endtask

  task automatic test_reenable();
    logic       en[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] wc[4] = '{8'd19, 8'd19, 8'd19, 8'd20};
    logic       wb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 4; c++) begin
      step(1'b0, en[c], 1'b0, 1'b0);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== e[i]) begin
          n_bad++;
          $display("FAIL reen%0d dut%0d got %h want %h", c, i, obs(i), e[i]);
        end
      end
      n_cmp++;
      if ({cc0, b0} !== {wc[c], wb[c]}) begin
        n_bad++;
        $display("FAIL reen_cnt%0d got cc=%0d busy=%b want %0d %b",
                 c, cc0, b0, wc[c], wb[c]);
      end
    end
  endtask

  task automatic test_rst_mid();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs(i) !== e[i]) begin
        n_bad++;
        $display("FAIL rstmid dut%0d got %h want %h", i, obs(i), e[i]);
      end
    end
    n_cmp++;
    if ({x0, r0, s0, ec0, cc0, b0, s1, b2} !== 22'd0) begin
      n_bad++;
      $display("FAIL rstmid_vals got %h want 0",
               {x0, r0, s0, ec0, cc0, b0, s1, b2});
    end
  endtask

  task automatic test_toggle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    void'(sb.pop_front());
    for (int c = 0; c < 9; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs(i) !== e[i]) begin
          n_bad++;
          $display("FAIL tog%0d dut%0d got %h want %h", c, i, obs(i), e[i]);
        end
      end
      n_cmp++;
      if (x0 !== ((c % 2) == 0)) begin
        n_bad++;
        $display("FAIL tog_exp%0d got %b want %b", c, x0, (c % 2) == 0);
      end
    end
    n_cmp++;
    if ({cc0, ec0, cc1, ec1} !== {8'd8, 8'd0, 8'd8, 8'd0}) begin
      n_bad++;
      $display("FAIL tog_cnt got %0d %0d %0d %0d want 8 0 8 0",
               cc0, ec0, cc1, ec1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
    test_reset();
    test_basic();
    test_force_err();
    test_saturate();
    test_reenable();
    test_rst_mid();
    test_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
